// File: rtl/pad_attr_ctrl.sv
// pad_attr_ctrl: pad-attribute write controller.
// Software writes are masked against the target pad's supported-attribute
// (WARL) mask. The result is held in a per-pad shadow register and then
// shifted MSB-first to the pad ring, followed by a one-cycle latch strobe.
// Optional build macro: PAD_ATTR_CTRL_PARITY_EN appends an even-parity bit
// (XOR of the masked word) after the data bits, so SHIFT is one cycle longer.
module pad_attr_ctrl #(
  parameter int NumPads = 4,
  parameter int AttrDw  = 32,
  parameter int PadIdxW = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumPads*AttrDw-1:0] warl_mask_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [PadIdxW-1:0]        req_pad_i,
  input  logic [AttrDw-1:0]         req_attr_i,
  output logic                      resp_valid_o,
  output logic                      resp_err_o,
  output logic [AttrDw-1:0]         resp_attr_o,
  output logic [NumPads*AttrDw-1:0] attr_o,
  output logic [PadIdxW-1:0]        pad_sel_o,
  output logic                      pad_shift_o,
  output logic                      pad_sdata_o,
  output logic                      pad_latch_o,
  output logic                      busy_o
);

`ifdef PAD_ATTR_CTRL_PARITY_EN
  localparam int ShW = AttrDw + 1;  // data bits followed by the parity bit
`else
  localparam int ShW = AttrDw;
`endif
  localparam int CntW = (ShW > 1) ? $clog2(ShW) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [AttrDw-1:0]   resp_attr_q, resp_attr_d;
  logic [PadIdxW-1:0]  pad_sel_q, pad_sel_d;
  logic [ShW-1:0]      shreg_q, shreg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [AttrDw-1:0]   shadow_q [NumPads];
  logic [AttrDw-1:0]   shadow_d [NumPads];

  logic [AttrDw-1:0]   warl_mask [NumPads];
  logic [AttrDw-1:0]   sel_mask;
  logic [AttrDw-1:0]   masked;
  logic                pad_hit;
  logic                accept;

  // Unpack the flat mask bus and pack the shadow registers onto attr_o.
  for (genvar gi = 0; gi < NumPads; gi++) begin : g_pad
    assign warl_mask[gi]                 = warl_mask_i[gi*AttrDw +: AttrDw];
    assign attr_o[gi*AttrDw +: AttrDw]   = shadow_q[gi];
  end

  // Select the target pad's mask; no match means the index is out of range.
  always_comb begin
    sel_mask = '0;
    pad_hit  = 1'b0;
    for (int k = 0; k < NumPads; k++) begin
      if (req_pad_i == PadIdxW'(k)) begin
        sel_mask = warl_mask[k];
        pad_hit  = 1'b1;
      end
    end
  end

  assign masked = req_attr_i & sel_mask;
  assign accept = req_valid_i & ready_q;

  // Next-state, shadow update and response generation.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_attr_d  = '0;
    pad_sel_d    = pad_sel_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          resp_valid_d = 1'b1;
          if (pad_hit) begin
            resp_attr_d = masked;
            for (int k = 0; k < NumPads; k++) begin
              if (req_pad_i == PadIdxW'(k)) shadow_d[k] = masked;
            end
`ifdef PAD_ATTR_CTRL_PARITY_EN
            shreg_d = {masked, ^masked};
`else
            shreg_d = masked;
`endif
            pad_sel_d = req_pad_i;
            cnt_d     = '0;
            state_d   = SHIFT;
          end else begin
            resp_err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ShW - 1)) state_d = LATCH;
      end
      LATCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready is registered so it tracks the state we are about to enter.
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers; reset aborts any shift in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_attr_q  <= '0;
      pad_sel_q    <= '0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      for (int k = 0; k < NumPads; k++) shadow_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_attr_q  <= resp_attr_d;
      pad_sel_q    <= pad_sel_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      for (int k = 0; k < NumPads; k++) shadow_q[k] <= shadow_d[k];
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_attr_o  = resp_attr_q;
  assign pad_sel_o    = pad_sel_q;
  assign pad_shift_o  = (state_q == SHIFT);
  assign pad_sdata_o  = (state_q == SHIFT) & shreg_q[ShW-1];
  assign pad_latch_o  = (state_q == LATCH);
  assign busy_o       = (state_q != IDLE);

endmodule
